xor_parity_accum: RTL and testbench
===================================

// Module: xor_parity_accum
// PURPOSE
//   Parametrised, clocked successor to the combinational XOR gate. Accumulates a
//   lane-wise XOR checksum and a single parity bit over a multi-beat packet on a
//   valid/ready stream. Presents one registered result per packet on a second
//   valid/ready port. Used as a lightweight integrity checker or generator on
//   datapath streams.
// PARAMETERS
//   WIDTH  8  data lane width in bits (>=1)
//   CNT_W  8  width of the beat counter; the count saturates at 2**CNT_W-1
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous reset, active-high
//   odd_mode    in   1        0 = even parity, 1 = odd parity; sampled on the first beat of each packet
//   in_valid    in   1        input beat valid
//   in_ready    out  1        block can accept a beat
//   in_data     in   WIDTH    input beat data
//   in_last     in   1        final beat of the packet
//   out_valid   out  1        result valid
//   out_ready   in   1        downstream accepts the result
//   out_xor     out  WIDTH    XOR of all beats in the packet
//   out_parity  out  1        ^out_xor, inverted when the latched odd_mode = 1
//   out_beats   out  CNT_W    number of beats in the packet (saturating)
// BEHAVIOUR
//   - One clock domain (clk). Reset is synchronous and active-high on rst.
//   - Reset (rst = 1 at a rising edge) sets:
//       state = ACCUM; accumulator = 0; count = 0; first = 1; out_valid = 0;
//       out_xor = 0; out_parity = 0; out_beats = 0.
//     While rst = 1, no beat is accepted, whatever in_ready shows.
//   - in_ready = (state == ACCUM), combinational from the state register.
//   - Beat acceptance: a beat is accepted when in_valid & in_ready at a rising edge.
//   - ACCUM state, on an accepted beat:
//       acc <= (first ? 0 : acc) ^ in_data
//       cnt <= first ? 1 : sat(cnt + 1)
//       if first, latch odd_mode
//       first <= in_last
//     On an accepted beat with in_last = 1:
//       out_xor <= new acc; out_beats <= new cnt;
//       out_parity <= (^new acc) ^ latched mode (the current odd_mode on a 1-beat packet);
//       out_valid <= 1; state <= HOLD.
//     Latency: out_valid rises the cycle after the last beat is accepted.
//   - HOLD state: in_ready = 0. The out_* outputs stay stable while out_valid & !out_ready.
//     On out_valid & out_ready: out_valid <= 0; state <= ACCUM.
//     There is no same-cycle bypass, so the minimum packet-to-packet spacing is 1 beat plus 1 cycle.
//   - out_xor, out_parity and out_beats keep their last values after the handshake.
//     They are meaningful only while out_valid = 1.
//   - The count saturates at 2**CNT_W-1. No wrap-around. The XOR accumulation itself has no limit.
//   - Stall: in_valid = 0 mid-packet holds acc, cnt and first unchanged for any number of cycles.
//   - Changes to odd_mode after the first beat have no effect on the current packet.
//   - Reset mid-packet or during HOLD discards the partial or pending result.
//     The next accepted beat starts a new packet.
//   - in_data and in_last are ignored when no beat is accepted.
// TESTING
//   1. WIDTH=8, even mode; beats A5, 3C, FF (last on FF)
//      -> out_xor=66, out_parity=0, out_beats=3, out_valid one cycle after the FF beat.
//   2. Same beats with odd_mode=1 on the first beat; toggle odd_mode to 0 on the 2nd beat
//      -> out_xor=66, out_parity=1.
//   3. Single beat 01, last=1, even mode
//      -> out_xor=01, out_parity=1, out_beats=1; in_ready=0 until the output handshake.
//   4. out_ready held low 5 cycles after out_valid
//      -> all out_* stable, in_ready=0; out_ready=1 gives out_valid=0 and in_ready=1 next cycle.
//   5. CNT_W=2, 5-beat packet of 00 -> out_beats=3 (saturated), out_xor=00, out_parity=0.
//   6. rst=1 after 2 of 3 beats; then a new 1-beat packet 0F
//      -> out_xor=0F, out_beats=1, no stale result ever asserted.

Source files
------------

// File: rtl/xor_parity_accum.sv
// Streaming XOR checksum and parity accumulator: folds every beat of a packet into a
// lane-wise XOR, counts the beats (saturating) and presents one registered result per packet.
module xor_parity_accum #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             odd_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_beats
);

   localparam logic ST_ACCUM = 1'b0;
   localparam logic ST_HOLD  = 1'b1;

   logic             r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_first;
   logic             r_mode;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_xor;
   logic             r_out_parity;
   logic [CNT_W-1:0] r_out_beats;

   logic             w_accept;
   logic [WIDTH-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_mode;
   logic             w_parity;

   assign in_ready   = (r_state == ST_ACCUM);
   assign w_accept   = in_valid & in_ready;

   // The first beat of a packet restarts the fold instead of extending the previous one.
   assign w_acc_next = (r_first ? '0 : r_acc) ^ in_data;
   assign w_cnt_next = r_first ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
   assign w_mode     = r_first ? odd_mode : r_mode;
   assign w_parity   = (^w_acc_next) ^ w_mode;

   // NOTE: every register here is written with <= so all of them sample the
   // pre-edge values; a blocking = would let later statements see updated state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_ACCUM;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_first      <= 1'b1;
         r_mode       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_xor    <= '0;
         r_out_parity <= 1'b0;
         r_out_beats  <= '0;
      end else if (r_state == ST_ACCUM) begin
         if (w_accept) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_mode  <= w_mode;
            r_first <= in_last;
            if (in_last) begin
               r_out_xor    <= w_acc_next;
               r_out_beats  <= w_cnt_next;
               r_out_parity <= w_parity;
               r_out_valid  <= 1'b1;
               r_state      <= ST_HOLD;
            end
         end
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_xor    = r_out_xor;
   assign out_parity = r_out_parity;
   assign out_beats  = r_out_beats;

endmodule

// File: tb/tb_xor_parity_accum.sv
// Bench for xor_parity_accum: two instances (CNT_W=8 and CNT_W=2) checked every cycle
// against a packet-level model, plus literal expectations for the directed packets.
module tb_xor_parity_accum;

   logic       clk = 1'b0;
   logic       rst_v  [2];
   logic       mode_v [2];
   logic       iv     [2];
   logic       ir     [2];
   logic [7:0] idat   [2];
   logic       il     [2];
   logic       ov     [2];
   logic       orr    [2];
   logic [7:0] oxor   [2];
   logic       opar   [2];
   logic [7:0] ob0;
   logic [1:0] ob1;
   logic [7:0] obeats [2];

   int n_cmp = 0;
   int n_err = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   xor_parity_accum #(.WIDTH(8), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst_v[0]), .odd_mode(mode_v[0]),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]), .in_last(il[0]),
      .out_valid(ov[0]), .out_ready(orr[0]), .out_xor(oxor[0]),
      .out_parity(opar[0]), .out_beats(ob0)
   );

   xor_parity_accum #(.WIDTH(8), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .odd_mode(mode_v[1]),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]), .in_last(il[1]),
      .out_valid(ov[1]), .out_ready(orr[1]), .out_xor(oxor[1]),
      .out_parity(opar[1]), .out_beats(ob1)
   );

   assign obeats[0] = ob0;
   assign obeats[1] = {6'b0, ob1};

   // ---------------- packet-level model ----------------
   localparam int MAXB = 64;
   logic [7:0] pk_d [2][MAXB];
   int         pk_n [2];
   logic       m_mode  [2];
   logic       m_valid [2];
   logic [7:0] m_xor   [2];
   logic       m_par   [2];
   int         m_beats [2];
   int         cnt_max [2] = '{255, 3};

   function automatic logic [7:0] fold_xor(input int k, input int n);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < n; i++) x = x ^ pk_d[k][i];
      return x;
   endfunction

   function automatic int sat_count(input int n, input int lim);
      return (n > lim) ? lim : n;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst_v[k]) begin
            m_valid[k] <= 1'b0;
            pk_n[k]    <= 0;
         end else if (m_valid[k]) begin
            if (orr[k]) m_valid[k] <= 1'b0;
         end else if (iv[k]) begin
            if (pk_n[k] == 0) m_mode[k] <= mode_v[k];
            pk_d[k][pk_n[k]] <= idat[k];
            pk_n[k] <= pk_n[k] + 1;
            if (il[k]) begin
               m_xor[k]   <= fold_xor(k, pk_n[k]) ^ idat[k];
               m_par[k]   <= (^(fold_xor(k, pk_n[k]) ^ idat[k])) ^
                             ((pk_n[k] == 0) ? mode_v[k] : m_mode[k]);
               m_beats[k] <= sat_count(pk_n[k] + 1, cnt_max[k]);
               m_valid[k] <= 1'b1;
               pk_n[k]    <= 0;
            end
         end
      end
   end

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            check("in_ready", k, 32'(ir[k]), 32'(!m_valid[k]));
            check("out_valid", k, 32'(ov[k]), 32'(m_valid[k]));
            if (m_valid[k]) begin
               check("out_xor", k, 32'(oxor[k]), 32'(m_xor[k]));
               check("out_parity", k, 32'(opar[k]), 32'(m_par[k]));
               check("out_beats", k, 32'(obeats[k]), 32'(m_beats[k]));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input int k, input logic [7:0] d, input logic last, input logic md);
      int t = 0;
      iv[k] = 1'b1; idat[k] = d; il[k] = last; mode_v[k] = md;
      while (ir[k] !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("beat_timeout", k, 32'd0, 32'd1);
      @(posedge clk); #1;
      iv[k] = 1'b0; il[k] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic take(input int k, input int hold);
      int t = 0;
      while (ov[k] !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("result_timeout", k, 32'd0, 32'd1);
      idle(hold);
      orr[k] = 1'b1;
      @(posedge clk); #1;
      orr[k] = 1'b0;
   endtask

   task automatic pulse_reset(input int k);
      rst_v[k] = 1'b1;
      @(posedge clk); #1;
      rst_v[k] = 1'b0;
   endtask

   task automatic expect_result(input int k, input logic [7:0] x, input logic p,
                                input int b);
      check("lit_valid", k, 32'(ov[k]), 32'd1);
      check("lit_xor", k, 32'(oxor[k]), 32'(x));
      check("lit_parity", k, 32'(opar[k]), 32'(p));
      check("lit_beats", k, 32'(obeats[k]), 32'(b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b1; mode_v[k] = 1'b0; iv[k] = 1'b0; idat[k] = 8'h00;
         il[k] = 1'b0; orr[k] = 1'b0;
      end
      @(posedge clk); #1;
      started = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_valid", k, 32'(ov[k]), 32'd0);
         check("rst_ready", k, 32'(ir[k]), 32'd1);
         check("rst_xor", k, 32'(oxor[k]), 32'd0);
         check("rst_parity", k, 32'(opar[k]), 32'd0);
         check("rst_beats", k, 32'(obeats[k]), 32'd0);
         rst_v[k] = 1'b0;
      end
      idle(1);

      // 1: even mode A5,3C,FF; result visible right after the last beat's edge
      beat(0, 8'hA5, 1'b0, 1'b0);
      beat(0, 8'h3C, 1'b0, 1'b0);
      beat(0, 8'hFF, 1'b1, 1'b0);
      expect_result(0, 8'h66, 1'b0, 3);
      take(0, 0);

      // 2: odd mode latched on the first beat, later toggle ignored
      beat(0, 8'hA5, 1'b0, 1'b1);
      beat(0, 8'h3C, 1'b0, 1'b0);
      beat(0, 8'hFF, 1'b1, 1'b0);
      expect_result(0, 8'h66, 1'b1, 3);
      take(0, 0);

      // 3 + 4: single beat, result held 5 cycles with out_ready low
      beat(0, 8'h01, 1'b1, 1'b0);
      expect_result(0, 8'h01, 1'b1, 1);
      check("hold_ready", 0, 32'(ir[0]), 32'd0);
      take(0, 5);
      check("post_valid", 0, 32'(ov[0]), 32'd0);
      check("post_ready", 0, 32'(ir[0]), 32'd1);

      // stall mid-packet: 10, three idle cycles, 20
      beat(0, 8'h10, 1'b0, 1'b0);
      idle(3);
      beat(0, 8'h20, 1'b1, 1'b0);
      expect_result(0, 8'h30, 1'b0, 2);
      take(0, 1);

      // 5: saturating count on the CNT_W=2 instance
      for (int i = 0; i < 5; i++) beat(1, 8'h00, (i == 4), 1'b0);
      expect_result(1, 8'h00, 1'b0, 3);
      take(1, 2);
      beat(1, 8'h81, 1'b0, 1'b1);
      beat(1, 8'h02, 1'b1, 1'b1);
      expect_result(1, 8'h83, 1'b0, 2);
      take(1, 0);

      // 6: reset after 2 of 3 beats discards the partial packet
      beat(0, 8'h11, 1'b0, 1'b0);
      beat(0, 8'h22, 1'b0, 1'b0);
      pulse_reset(0);
      check("mid_rst_valid", 0, 32'(ov[0]), 32'd0);
      beat(0, 8'h0F, 1'b1, 1'b0);
      expect_result(0, 8'h0F, 1'b0, 1);

      // reset during HOLD drops the pending result
      pulse_reset(0);
      check("hold_rst_valid", 0, 32'(ov[0]), 32'd0);
      check("hold_rst_ready", 0, 32'(ir[0]), 32'd1);
      beat(0, 8'h07, 1'b0, 1'b1);
      beat(0, 8'h70, 1'b1, 1'b0);
      expect_result(0, 8'h77, 1'b1, 2);
      take(0, 0);

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
